// File: rtl/renode_bus_arbiter.sv
// renode_bus_arbiter
//   Shares one single-outstanding bus-controller port between Requesters
//   transaction sources: the Renode-driven read/write path and local masters.
//   Grants are round-robin, and only one transaction is in flight at a time.
//   A per-transaction timeout aborts the controller. Ok/error/read data is
//   returned to the granted source only.
//
// Ports
//   clk, rst                   clock (posedge); asynchronous active-high reset
//   req_valid/req_write        per-source request strobe and direction
//   req_addr/req_wdata         packed per-source fields, source i at [i*W +: W]
//   req_ready                  1-cycle pulse: request of source i latched
//   resp_valid                 1-cycle pulse: response for source i
//   resp_rdata/resp_error      response payload, zero when no resp_valid is set
//   ctrl_valid/ready           offer of the latched transaction to the controller
//   ctrl_write/addr/wdata      latched transaction fields
//   ctrl_done/rdata/error      completion from the controller
//   ctrl_abort                 1-cycle pulse: controller must drop the transaction
module renode_bus_arbiter #(
  parameter int Requesters    = 2,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 100
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [Requesters-1:0]              req_valid,
  input  logic [Requesters-1:0]              req_write,
  input  logic [Requesters*AddressWidth-1:0] req_addr,
  input  logic [Requesters*DataWidth-1:0]    req_wdata,
  output logic [Requesters-1:0]              req_ready,
  output logic [Requesters-1:0]              resp_valid,
  output logic [DataWidth-1:0]               resp_rdata,
  output logic                               resp_error,
  output logic                               ctrl_valid,
  output logic                               ctrl_write,
  output logic [AddressWidth-1:0]            ctrl_addr,
  output logic [DataWidth-1:0]               ctrl_wdata,
  input  logic                               ctrl_ready,
  input  logic                               ctrl_done,
  input  logic [DataWidth-1:0]               ctrl_rdata,
  input  logic                               ctrl_error,
  output logic                               ctrl_abort
);

  localparam int PW = (Requesters > 1) ? $clog2(Requesters) : 1;
  localparam int CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [PW-1:0] LAST_SRC = PW'(Requesters - 1);
  // The abort fires on the edge that would bring the counter to TimeoutCycles.
  localparam logic [CW-1:0] LAST_CNT = (TimeoutCycles > 0) ? CW'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t                  state, state_n;
  logic [PW-1:0]           ptr, ptr_n, gnt, gnt_n, pick;
  logic [CW-1:0]           cnt, cnt_n;
  logic [DataWidth-1:0]    rdata_q, rdata_n;
  logic                    err_q, err_n;
  logic                    write_n, valid_n, abort_n, resp_error_n;
  logic [AddressWidth-1:0] addr_n;
  logic [DataWidth-1:0]    wdata_n, resp_rdata_n;
  logic [Requesters-1:0]   req_ready_n, resp_valid_n, rot;
  logic [2*Requesters-1:0] dbl;
  logic [PW:0]             sum;
  logic                    timeout;

  assign timeout = (TimeoutCycles != 0) && (cnt == LAST_CNT);

  // Rotate the request vector so bit 0 is the pointer's source, take the
  // lowest set bit, then map the offset back to an absolute source index.
  always_comb begin
    dbl = {req_valid, req_valid} >> ptr;
    rot = dbl[Requesters-1:0];
    sum = '0;
    for (int i = Requesters - 1; i >= 0; i--) begin
      if (rot[i]) sum = {1'b0, ptr} + (PW+1)'(i);
    end
    if (sum >= (PW+1)'(Requesters)) sum = sum - (PW+1)'(Requesters);
    pick = sum[PW-1:0];
  end

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    gnt_n        = gnt;
    cnt_n        = cnt;
    write_n      = ctrl_write;
    addr_n       = ctrl_addr;
    wdata_n      = ctrl_wdata;
    rdata_n      = rdata_q;
    err_n        = err_q;
    req_ready_n  = '0;
    resp_valid_n = '0;
    resp_rdata_n = '0;
    resp_error_n = 1'b0;
    valid_n      = 1'b0;
    abort_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          gnt_n       = pick;
          write_n     = req_write[pick];
          addr_n      = req_addr[pick*AddressWidth +: AddressWidth];
          wdata_n     = req_wdata[pick*DataWidth +: DataWidth];
          req_ready_n = Requesters'(1) << pick;
          valid_n     = 1'b1;
          cnt_n       = '0;
          state_n     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // ctrl_done is deliberately ignored until the controller has accepted.
        cnt_n = cnt + 1'b1;
        if (timeout) begin
          abort_n = 1'b1;
          rdata_n = '0;
          err_n   = 1'b1;
          state_n = S_RESPOND;
        end else if (ctrl_ready) begin
          state_n = S_WAIT;
        end else begin
          valid_n = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_n = cnt + 1'b1;
        // A completion on the timeout cycle takes precedence over the abort.
        if (ctrl_done) begin
          rdata_n = ctrl_write ? '0 : ctrl_rdata;
          err_n   = ctrl_error;
          state_n = S_RESPOND;
        end else if (timeout) begin
          abort_n = 1'b1;
          rdata_n = '0;
          err_n   = 1'b1;
          state_n = S_RESPOND;
        end
      end
      S_RESPOND: begin
        resp_valid_n = Requesters'(1) << gnt;
        resp_rdata_n = rdata_q;
        resp_error_n = err_q;
        ptr_n        = (gnt == LAST_SRC) ? '0 : gnt + 1'b1;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      gnt        <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      ctrl_valid <= 1'b0;
      ctrl_write <= 1'b0;
      ctrl_addr  <= '0;
      ctrl_wdata <= '0;
      ctrl_abort <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      gnt        <= gnt_n;
      cnt        <= cnt_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_error <= resp_error_n;
      ctrl_valid <= valid_n;
      ctrl_write <= write_n;
      ctrl_addr  <= addr_n;
      ctrl_wdata <= wdata_n;
      ctrl_abort <= abort_n;
    end
  end

  // Completion payload is only consumed in RESPOND, after it has been written.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_n;
    err_q   <= err_n;
  end

endmodule

// File: tb/tb_renode_bus_arbiter.sv
`timescale 1ns/1ps
module tb_renode_bus_arbiter;
  localparam int R  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [R-1:0]  req_valid = '0, req_write = '0;
  logic [R*AW-1:0] req_addr = '0;
  logic [R*DW-1:0] req_wdata = '0;
  logic [R-1:0]  req_ready, resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_error, ctrl_valid, ctrl_write, ctrl_abort;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_wdata;
  logic          ctrl_ready = 1'b0, ctrl_done = 1'b0, ctrl_error = 1'b0;
  logic [DW-1:0] ctrl_rdata = '0;

  renode_bus_arbiter #(.Requesters(R), .AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .ctrl_valid(ctrl_valid), .ctrl_write(ctrl_write), .ctrl_addr(ctrl_addr),
    .ctrl_wdata(ctrl_wdata), .ctrl_ready(ctrl_ready), .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata),
    .ctrl_error(ctrl_error), .ctrl_abort(ctrl_abort));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Knobs, written only by the main sequence.
  int          quota [R];
  bit          fixed_mode;
  logic        fx_write [R];
  logic [31:0] fx_addr [R];
  logic [31:0] fx_wdata [R];
  int          k_wait, k_done, k_err;
  logic [31:0] k_rdata;
  bit          k_rnd_rdata, k_gaps, k_spurious;

  // Stimulus driver: requesters and bus controller, all on the falling edge.
  int issued [R];
  int vcount = 0, cur_wait = 0, dcnt = 0;
  bit last_ready = 0, waiting = 0;

  initial begin
    for (int i = 0; i < R; i++) begin
      quota[i] = 0; issued[i] = 0; fx_write[i] = 0; fx_addr[i] = '0; fx_wdata[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < R; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        issued[i]++;
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && issued[i] < quota[i] && (!k_gaps || $urandom_range(0, 2) == 0)) begin
        req_valid[i] = 1'b1;
        if (fixed_mode) begin
          req_write[i] = fx_write[i];
          req_addr[i*AW +: AW] = fx_addr[i];
          req_wdata[i*DW +: DW] = fx_wdata[i];
        end else begin
          req_write[i] = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW] = $urandom;
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
    end
    ctrl_ready = 1'b0;
    ctrl_done  = 1'b0;
    if (rst || ctrl_abort) begin
      vcount = 0; last_ready = 0; waiting = 0;
    end else begin
      if (last_ready) begin
        last_ready = 0;
        waiting = 1;
        dcnt = (k_done < 0) ? $urandom_range(1, 9) : k_done;
      end
      if (waiting) begin
        if (dcnt == 1) begin
          ctrl_done  = 1'b1;
          waiting    = 0;
          ctrl_error = (k_err < 0) ? 1'($urandom_range(0, 1)) : k_err[0];
          ctrl_rdata = k_rnd_rdata ? $urandom : k_rdata;
        end else if (dcnt > 1) begin
          dcnt--;
        end
      end
      if (ctrl_valid) begin
        if (vcount == 0) cur_wait = (k_wait < 0) ? $urandom_range(0, 3) : k_wait;
        if (vcount >= cur_wait) begin
          ctrl_ready = 1'b1;
          last_ready = 1;
        end
        vcount++;
        if (k_spurious && $urandom_range(0, 3) == 0) begin
          ctrl_done  = 1'b1;
          ctrl_rdata = $urandom;
          ctrl_error = 1'($urandom_range(0, 1));
        end
      end else begin
        vcount = 0;
      end
    end
  end

  // Transaction-level reference: one record for the transaction in flight,
  // aged in cycles since its grant; expected outputs follow from that record.
  bit          m_busy = 0, m_acc = 0, m_resp = 0, m_wr = 0, m_err = 0;
  int          m_src = 0, m_age = 0, m_ptr = 0;
  logic [31:0] m_rd = '0;
  logic [R-1:0] e_req_ready = '0, e_resp_valid = '0;
  logic [31:0] e_resp_rdata = '0, e_ctrl_addr = '0, e_ctrl_wdata = '0;
  bit          e_resp_error = 0, e_ctrl_valid = 0, e_ctrl_write = 0, e_ctrl_abort = 0;

  always @(posedge clk) begin
    bit fire_to;
    fire_to = 0;
    e_req_ready = '0; e_resp_valid = '0; e_resp_rdata = '0;
    e_resp_error = 0; e_ctrl_valid = 0; e_ctrl_abort = 0;
    if (rst) begin
      m_busy = 0; m_ptr = 0;
      e_ctrl_write = 0; e_ctrl_addr = '0; e_ctrl_wdata = '0;
    end else if (m_busy && m_resp) begin
      e_resp_valid[m_src] = 1'b1;
      e_resp_rdata = m_rd;
      e_resp_error = m_err;
      m_ptr = (m_src + 1) % R;
      m_busy = 0;
    end else if (m_busy) begin
      m_age++;
      if (!m_acc) begin
        if (m_age == TO) fire_to = 1;
        else if (ctrl_ready) m_acc = 1;
        else e_ctrl_valid = 1;
      end else if (ctrl_done) begin
        m_rd = m_wr ? 32'h0 : ctrl_rdata;
        m_err = ctrl_error;
        m_resp = 1;
      end else if (m_age == TO) begin
        fire_to = 1;
      end
      if (fire_to) begin
        e_ctrl_abort = 1; m_err = 1; m_rd = '0; m_resp = 1;
      end
    end else if (req_valid != '0) begin
      for (int k = R - 1; k >= 0; k--)
        if (req_valid[(m_ptr + k) % R]) m_src = (m_ptr + k) % R;
      m_busy = 1; m_acc = 0; m_resp = 0; m_age = 0;
      m_wr = req_write[m_src];
      e_ctrl_write = m_wr;
      e_ctrl_addr  = req_addr[m_src*AW +: AW];
      e_ctrl_wdata = req_wdata[m_src*DW +: DW];
      e_req_ready[m_src] = 1'b1;
      e_ctrl_valid = 1;
    end
  end

  always @(negedge clk) begin
    chk("req_ready",  req_ready,  rst ? '0 : e_req_ready);
    chk("resp_valid", resp_valid, rst ? '0 : e_resp_valid);
    chk("resp_rdata", resp_rdata, rst ? '0 : e_resp_rdata);
    chk("resp_error", resp_error, rst ? 1'b0 : e_resp_error);
    chk("ctrl_valid", ctrl_valid, rst ? 1'b0 : e_ctrl_valid);
    chk("ctrl_write", ctrl_write, rst ? 1'b0 : e_ctrl_write);
    chk("ctrl_addr",  ctrl_addr,  rst ? '0 : e_ctrl_addr);
    chk("ctrl_wdata", ctrl_wdata, rst ? '0 : e_ctrl_wdata);
    chk("ctrl_abort", ctrl_abort, rst ? 1'b0 : e_ctrl_abort);
  end

  function automatic logic [127:0] all_outputs();
    return {req_ready, resp_valid, resp_rdata, resp_error, ctrl_valid, ctrl_write,
            ctrl_addr, ctrl_wdata, ctrl_abort};
  endfunction

  // Cycle 0 is the falling edge on which the driver raises req_valid.
  int t_ready, t_abort, t_resp, n_valid;
  logic [R-1:0] o_rv;
  logic [31:0]  o_rd, f_addr, f_wdata;
  bit           o_re, f_write, stable;

  task automatic observe(input int budget);
    t_ready = -1; t_abort = -1; t_resp = -1; n_valid = 0; stable = 1;
    o_rv = '0; o_rd = '0; o_re = 0; f_addr = '0; f_wdata = '0; f_write = 0;
    @(negedge clk);
    for (int k = 1; k <= budget && t_resp < 0; k++) begin
      @(negedge clk);
      if (req_ready != '0 && t_ready < 0) t_ready = k;
      if (ctrl_abort && t_abort < 0) t_abort = k;
      if (ctrl_valid) begin
        if (n_valid == 0) begin
          f_addr = ctrl_addr; f_wdata = ctrl_wdata; f_write = ctrl_write;
        end else if (ctrl_addr !== f_addr || ctrl_wdata !== f_wdata || ctrl_write !== f_write) begin
          stable = 0;
        end
        n_valid++;
      end
      if (resp_valid != '0) begin
        t_resp = k; o_rv = resp_valid; o_rd = resp_rdata; o_re = resp_error;
      end
    end
    chk("resp_within_budget", t_resp >= 0, 1'b1);
  endtask

  task automatic gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  int order [$];
  int n_ready;
  bit abort_seen;

  initial begin
    fixed_mode = 1; k_wait = 0; k_done = 1; k_err = 0; k_rdata = '0;
    k_rnd_rdata = 0; k_gaps = 0; k_spurious = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outputs(), '0);
    rst = 1'b0;
    gap();

    // Single read
    fx_write[0] = 0; fx_addr[0] = 32'h0000_1000; k_rdata = 32'hDEAD_BEEF;
    quota[0] = quota[0] + 1;
    observe(20);
    chk("t1_ready_cycle", t_ready, 1);
    chk("t1_latency", t_resp, 4);
    chk("t1_resp_src", o_rv, 2'b01);
    chk("t1_rdata", o_rd, 32'hDEAD_BEEF);
    chk("t1_error", o_re, 1'b0);
    chk("t1_addr", f_addr, 32'h0000_1000);
    gap();

    // Contention from reset
    rst = 1'b1;
    fx_write[0] = 0; fx_addr[0] = 32'h2000;
    fx_write[1] = 0; fx_addr[1] = 32'h3000;
    quota[0] = quota[0] + 2; quota[1] = quota[1] + 2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    order.delete(); n_ready = 0;
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      @(negedge clk);
      n_ready += $countones(req_ready);
      if (resp_valid == 2'b01) order.push_back(0);
      else if (resp_valid == 2'b10) order.push_back(1);
      else if (resp_valid != '0) order.push_back(9);
    end
    chk("t2_resp_count", order.size(), 4);
    chk("t2_order", {order.size() > 0 ? order[0] : -1, order.size() > 1 ? order[1] : -1,
                     order.size() > 2 ? order[2] : -1, order.size() > 3 ? order[3] : -1},
        {32'd0, 32'd1, 32'd0, 32'd1});
    chk("t2_ready_count", n_ready, 4);
    gap();

    // Timeout: accepted, never completed
    k_done = 0; fx_addr[0] = 32'h4000;
    quota[0] = quota[0] + 1;
    observe(30);
    chk("t3_abort_after_grant", t_abort - t_ready, TO);
    chk("t3_resp_cycle", t_resp, 10);
    chk("t3_error", o_re, 1'b1);
    chk("t3_rdata", o_rd, 32'h0);
    gap();

    // Completion on the timeout cycle
    k_done = 7; k_err = 1; k_rdata = 32'h5555_AAAA;
    quota[0] = quota[0] + 1;
    observe(30);
    chk("t4_no_abort", t_abort, -1);
    chk("t4_error", o_re, 1'b1);
    chk("t4_resp_cycle", t_resp, 10);
    chk("t4_rdata", o_rd, 32'h5555_AAAA);
    gap();

    // Backpressure on a write
    k_wait = 5; k_done = 1; k_err = 0; k_rdata = 32'h7777_7777;
    fx_write[1] = 1; fx_addr[1] = 32'hA5A5_0040; fx_wdata[1] = 32'h0BAD_F00D;
    quota[1] = quota[1] + 1;
    observe(30);
    chk("t5_valid_cycles", n_valid, 6);
    chk("t5_fields_stable", stable, 1'b1);
    chk("t5_addr", f_addr, 32'hA5A5_0040);
    chk("t5_wdata", f_wdata, 32'h0BAD_F00D);
    chk("t5_write", f_write, 1'b1);
    chk("t5_resp", {o_rv, o_re, o_rd}, {2'b10, 1'b0, 32'h0});
    chk("t5_resp_cycle", t_resp, 9);
    gap();

    // Reset while waiting on the controller
    k_wait = 0; k_done = 0;
    quota[0] = quota[0] + 1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("t6_outputs_in_reset", all_outputs(), '0);
    k_done = 1; k_err = 0;
    quota[0] = quota[0] + 1; quota[1] = quota[1] + 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    abort_seen = 0;
    o_rv = '0;
    for (int k = 0; k < 10 && o_rv == '0; k++) begin
      @(negedge clk);
      if (ctrl_abort || resp_valid != '0) abort_seen = 1;
      o_rv = req_ready;
    end
    chk("t6_first_grant", o_rv, 2'b01);
    chk("t6_no_stale_activity", abort_seen, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    // Randomized traffic
    fixed_mode = 0; k_wait = -1; k_done = -1; k_err = -1;
    k_rnd_rdata = 1; k_gaps = 1; k_spurious = 1;
    quota[0] = quota[0] + 40; quota[1] = quota[1] + 40;
    for (int c = 0; c < 6000 && (issued[0] < quota[0] || issued[1] < quota[1]); c++)
      @(posedge clk);
    chk("rand_all_issued", {issued[0] >= quota[0], issued[1] >= quota[1]}, 2'b11);
    repeat (30) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
